uart_tx: RTL

//   Serial UART transmitter fed directly by the UART register block (data byte, baud divisor, start
//   bit). Generates 8N1 frames (optionally 8E1) on the tx line, LSB first.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_if.sv | 24 ++
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_tx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and default sizing, used by uart_tx and uart_baud_gen.
package uart_pkg;

    localparam int unsigned UART_DBIT    = 8;
    localparam int unsigned UART_OS_TICK = 16;
    localparam int unsigned UART_DVSR_W  = 11;

    // PARITY keeps its code in every build so state encodings never shift
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Register-file side of the UART transmitter: frame request, payload, divisor and status.
interface uart_tx_if #(
    parameter int unsigned DBIT   = uart_pkg::UART_DBIT,
    parameter int unsigned DVSR_W = uart_pkg::UART_DVSR_W
) ();

    logic [DVSR_W-1:0] dvsr;
    logic [DBIT-1:0]   data_in;
    logic              tx_start;
    logic              tx;
    logic              tx_busy;
    logic              tx_done;

    modport master (
        output dvsr, data_in, tx_start,
        input  tx, tx_busy, tx_done
    );

    modport slave (
        input  dvsr, data_in, tx_start,
        output tx, tx_busy, tx_done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Baud tick generator: free-running 0..dvsr counter, one-cycle tick on wrap.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DVSR_W = UART_DVSR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DVSR_W-1:0] dvsr_i,
    input  logic              clear_i,
    output logic              tick_c_o
);

    logic [DVSR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || (cnt_q == dvsr_i)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DVSR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c_o = ~clear_i & (cnt_q == dvsr_i);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for an even-parity bit (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = UART_DBIT,
    parameter int unsigned OS_TICK = UART_OS_TICK,
    parameter int unsigned DVSR_W  = UART_DVSR_W
) (
    input logic      clk,
    input logic      rst_n,
    uart_tx_if.slave bus
);

    localparam int unsigned TICK_W = (OS_TICK > 1) ? $clog2(OS_TICK) : 1;
    localparam int unsigned BIT_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

    uart_tx_state_t    state_q, state_d;
    logic              start_q;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DBIT-1:0]   shift_q, shift_d;
    logic [DVSR_W-1:0] dvsr_q, dvsr_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic req_c;
    logic tick_c;
    logic bit_end_c;
    logic clear_c;

    // Only a rising edge of the level-type start register counts as a request
    assign req_c     = bus.tx_start & ~start_q;
    assign bit_end_c = tick_c & (tick_cnt_q == TICK_W'(OS_TICK - 1));

    uart_baud_gen #(
        .DVSR_W (DVSR_W)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .dvsr_i   (dvsr_q),
        .clear_i  (clear_c),
        .tick_c_o (tick_c)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        dvsr_d     = dvsr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        clear_c    = 1'b0;
        tx_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if ((state_q != IDLE) && tick_c) begin
            tick_cnt_d = bit_end_c ? '0 : tick_cnt_q + TICK_W'(1);
        end

        // tx_d follows the current state, so the line lags the FSM by one clock
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    state_d    = START;
                    shift_d    = DBIT'(bus.data_in);
                    dvsr_d     = DVSR_W'(bus.dvsr);
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    busy_d     = 1'b1;
                    clear_c    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^bus.data_in;
`endif
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end_c) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(DBIT - 1)) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = parity_q;
                if (bit_end_c) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            dvsr_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            start_q    <= bus.tx_start;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            dvsr_q     <= dvsr_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule
